// File: rtl/ln_scheduler.sv
// ln_scheduler: round-robin owner of one layer-norm engine; watchdog optional via LN_SCHED_TIMEOUT_EN
module ln_scheduler #(
   parameter int N_REQ          = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_REQ-1:0]         req,
   output logic [N_REQ-1:0]         grant,
   output logic [N_REQ-1:0]         ack,
   output logic [$clog2(N_REQ)-1:0] ln_sel,
   output logic                     ln_start,
   input  logic                     ln_done,
   output logic                     busy,
   output logic                     err,
   output logic [$clog2(N_REQ)-1:0] err_id
);
   localparam int W = $clog2(N_REQ);
   typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;
   state_t state_q, state_d;
   logic [W-1:0] ptr_q, ptr_d, win, idx, ln_sel_q;
   logic [N_REQ-1:0] grant_q, ack_q, oh_d;
   logic ln_start_q, busy_q, to_hit;
   // round-robin winner: nearest requester above the pointer, wrapping
   always_comb begin
      win = ptr_q;
      idx = '0;
      for (int i = N_REQ; i >= 1; i--) begin
         idx = W'((int'(ptr_q) + i) % N_REQ);
         if (req[idx]) win = idx;
      end
   end
   // next state; the pointer doubles as the current owner
   always_comb begin
      state_d = state_q;
      ptr_d = ptr_q;
      case (state_q)
         IDLE:    if (|req) begin state_d = START; ptr_d = win; end
         START:   state_d = WAIT;
         WAIT:    if (ln_done || to_hit) state_d = DONE;
         default: state_d = IDLE;
      endcase
   end
   assign oh_d = N_REQ'(1) << ptr_d;
   // state and all outputs registered from next-state values
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         ptr_q      <= W'(N_REQ - 1);
         grant_q    <= '0;
         ack_q      <= '0;
         ln_sel_q   <= '0;
         ln_start_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         grant_q    <= (state_d != IDLE) ? oh_d : '0;
         ack_q      <= (state_d == DONE) ? oh_d : '0;
         ln_sel_q   <= (state_d != IDLE) ? ptr_d : '0;
         ln_start_q <= state_d == START;
         busy_q     <= state_d != IDLE;
      end
   end
   assign grant    = grant_q;
   assign ack      = ack_q;
   assign ln_sel   = ln_sel_q;
   assign ln_start = ln_start_q;
   assign busy     = busy_q;
`ifdef LN_SCHED_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] wd_q, wd_d;
   logic err_q, err_d;
   logic [W-1:0] err_id_q;
   assign to_hit = (state_q == WAIT) && (wd_q == CW'(TIMEOUT_CYCLES - 1));
   assign err_d  = to_hit && !ln_done;
   assign wd_d   = (state_d == START) ? '0 : (state_q == WAIT) ? wd_q + 1'b1 : wd_q;
   // watchdog counts WAIT cycles and records the owner that timed out
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wd_q     <= '0;
         err_q    <= 1'b0;
         err_id_q <= '0;
      end else begin
         wd_q     <= wd_d;
         err_q    <= err_d;
         err_id_q <= err_d ? ptr_q : err_id_q;
      end
   end
   assign err    = err_q;
   assign err_id = err_id_q;
`else
   assign to_hit = 1'b0;
   assign err    = TIMEOUT_CYCLES < 0;
   assign err_id = '0;
`endif
endmodule

// File: tb/tb_ln_scheduler.sv
// tb_ln_scheduler: vector table, corner sequences and randomized jobs against an arithmetic round-robin model
module tb_ln_scheduler;
   localparam int N = 4;
   logic clk = 1'b0, rst = 1'b0, ln_done = 1'b0;
   logic [N-1:0] req = '0, grant, ack;
   logic [1:0] ln_sel, err_id;
   logic ln_start, busy, err;
   int pass_cnt = 0, total = 0;
   typedef struct {
      logic [3:0] req;
      int         dly;
      logic [3:0] grant;
      logic [1:0] sel;
   } vec_t;
   vec_t vt [8];

   ln_scheduler #(.N_REQ(N), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst(rst), .req(req), .grant(grant), .ack(ack), .ln_sel(ln_sel),
      .ln_start(ln_start), .ln_done(ln_done), .busy(busy), .err(err), .err_id(err_id)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = '0;
      ln_done = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      int ptr, w, ew;
      logic [3:0] r, eg;
      // table: each row is a full job; expected winner follows the pointer left by earlier rows
      vt[0] = '{4'b0100, 20, 4'b0100, 2'd2};
      vt[1] = '{4'b0101,  3, 4'b0001, 2'd0};
      vt[2] = '{4'b0101,  1, 4'b0100, 2'd2};
      vt[3] = '{4'b1000,  2, 4'b1000, 2'd3};
      vt[4] = '{4'b0011,  1, 4'b0001, 2'd0};
      vt[5] = '{4'b0011,  4, 4'b0010, 2'd1};
      vt[6] = '{4'b0011,  2, 4'b0001, 2'd0};
      vt[7] = '{4'b1111,  1, 4'b0010, 2'd1};
      do_reset();
      check("reset_outputs", {grant, ack, ln_sel, ln_start, busy, err, err_id}, 0);
      for (int i = 0; i < 8; i++) begin
         req = vt[i].req;
         tick();
         check($sformatf("v%0d_start", i), {grant, ln_sel, ln_start, busy}, {vt[i].grant, vt[i].sel, 1'b1, 1'b1});
         tick();
         check($sformatf("v%0d_wait", i), {grant, ln_sel, ln_start, ack}, {vt[i].grant, vt[i].sel, 1'b0, 4'b0});
         repeat (vt[i].dly - 1) tick();
         ln_done = 1'b1;
         tick();
         ln_done = 1'b0;
         check($sformatf("v%0d_ack", i), {ack, grant}, {vt[i].grant, vt[i].grant});
         req = '0;
         tick();
         check($sformatf("v%0d_idle", i), {busy, grant, ack, ln_start}, 0);
      end
      // fairness with all requests held through their acks
      do_reset();
      req = 4'hF;
      for (int j = 0; j < 5; j++) begin
         eg = 4'(1 << (j % 4));
         tick();
         check($sformatf("fair%0d_grant", j), {grant, ln_start}, {eg, 1'b1});
         tick();
         ln_done = 1'b1;
         tick();
         ln_done = 1'b0;
         check($sformatf("fair%0d_ack", j), ack, eg);
         tick();
         check($sformatf("fair%0d_gap", j), {busy, grant}, 0);
      end
      req = '0;
      // spurious done in IDLE and START
      do_reset();
      ln_done = 1'b1;
      tick();
      check("spur_idle", {busy, ack}, 0);
      req = 4'b0001;
      tick();
      check("spur_start", {grant, ln_start}, {4'b0001, 1'b1});
      tick();
      check("spur_wait", {busy, ack, ln_start}, {1'b1, 4'b0, 1'b0});
      ln_done = 1'b0;
      tick();
      check("spur_hold", {busy, ack}, {1'b1, 4'b0});
      ln_done = 1'b1;
      tick();
      ln_done = 1'b0;
      check("spur_ack", ack, 4'b0001);
      req = '0;
      tick();
      check("spur_end", {busy, grant}, 0);
      // owner drops its request mid-job
      do_reset();
      req = 4'b0010;
      tick();
      check("drop_grant", grant, 4'b0010);
      tick();
      req = '0;
      tick();
      ln_done = 1'b1;
      tick();
      ln_done = 1'b0;
      check("drop_ack", ack, 4'b0010);
      tick();
      tick();
      check("drop_nogrant", {busy, grant}, 0);
      // reset during WAIT abandons the job at once
      req = 4'b0100;
      tick();
      tick();
      tick();
      check("rstjob_busy", {busy, grant}, {1'b1, 4'b0100});
      rst = 1'b1;
      #1;
      check("rstjob_async", {grant, ack, ln_sel, ln_start, busy, err, err_id}, 0);
      tick();
      rst = 1'b0;
      req = 4'b0001;
      tick();
      check("rstjob_regrant", {grant, ln_sel}, {4'b0001, 2'd0});
      tick();
      ln_done = 1'b1;
      tick();
      ln_done = 1'b0;
      req = '0;
      tick();
`ifdef LN_SCHED_TIMEOUT_EN
      do_reset();
      req = 4'b0100;
      tick();
      repeat (16) tick();
      check("to_pre", {busy, err, ack}, {1'b1, 1'b0, 4'b0});
      tick();
      check("to_err", {err, ack, err_id}, {1'b1, 4'b0100, 2'd2});
      req = '0;
      tick();
      check("to_idle", {busy, err, err_id}, {1'b0, 1'b0, 2'd2});
`else
      do_reset();
      req = 4'b0100;
      tick();
      repeat (40) tick();
      check("nto_wait", {busy, err, ack, err_id}, {1'b1, 1'b0, 4'b0, 2'd0});
      ln_done = 1'b1;
      tick();
      ln_done = 1'b0;
      check("nto_ack", {ack, err}, {4'b0100, 1'b0});
      req = '0;
      tick();
`endif
      // randomized jobs against the round-robin model
      do_reset();
      ptr = N - 1;
      for (int j = 0; j < 30; j++) begin
         r = 4'($urandom_range(1, 15));
         w = -1;
         for (int k = 1; k <= N; k++) begin
            ew = (ptr + k) % N;
            if (w < 0 && r[ew]) w = ew;
         end
         ptr = w;
         eg = 4'(1 << w);
         req = r;
         ln_done = 1'($urandom);
         tick();
         check($sformatf("rnd%0d_grant", j), {grant, ln_sel, ln_start}, {eg, 2'(w), 1'b1});
         if ($urandom_range(0, 1) == 1) req = '0;
         ln_done = 1'($urandom);
         tick();
         ln_done = 1'b0;
         repeat ($urandom_range(0, 4)) tick();
         ln_done = 1'b1;
         tick();
         ln_done = 1'b0;
         check($sformatf("rnd%0d_ack", j), {ack, grant}, {eg, eg});
         req = '0;
         tick();
         check($sformatf("rnd%0d_idle", j), {busy, ack}, 0);
      end
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule

// File: doc/ln_scheduler.md
LN_SCHEDULER -- requirements
Module: ln_scheduler

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters sharing one layer-norm engine (2..16).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, watchdog limit in cycles (used only under REQ-026).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req  input  N_REQ  per-requester job request; requester holds it high until its ack.
REQ-006 SHALL have port grant  output  N_REQ  one-hot owner of the engine; zero when idle.
REQ-007 SHALL have port ack  output  N_REQ  one-cycle pulse to the owner at job end.
REQ-008 SHALL have port ln_sel  output  $clog2(N_REQ)  index of the owner, driving the x_in/gamma_in/beta_in muxes.
REQ-009 SHALL have port ln_start  output  1  one-cycle start pulse to the engine.
REQ-010 SHALL have port ln_done  input  1  engine completion pulse.
REQ-011 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-012 SHALL have port err  output  1  one-cycle timeout pulse.
REQ-013 SHALL have port err_id  output  $clog2(N_REQ)  owner index captured on timeout; holds until the next timeout.

Function
REQ-014 SHALL implement the states IDLE, START, WAIT and DONE; every output SHALL be registered.
REQ-015 In IDLE with any req bit high at an edge, the block SHALL latch the round-robin winner and move to START.
REQ-016 Round-robin SHALL search from pointer+1 upward with wrap; pointer SHALL update to the winner on each grant.
REQ-017 In START (exactly one cycle), grant[w]=1, ln_sel=w and ln_start=1; the next state SHALL be WAIT.
REQ-018 In WAIT, grant and ln_sel SHALL hold and ln_start=0; ln_done sampled high SHALL move the block to DONE.
REQ-019 In DONE (one cycle), ack[w]=1 and grant[w] stays 1; the next state SHALL be IDLE with grant=0.
REQ-020 Minimum latency SHALL be: req sampled at edge k, ln_start high in cycle k+1, ack in the cycle after ln_done is sampled.
REQ-021 ln_done SHALL be ignored in IDLE, START and DONE; a late or spurious pulse SHALL have no effect.
REQ-022 If the owner drops req mid-job, the job SHALL complete normally and ack SHALL still pulse.
REQ-023 A req held through ack SHALL lose to any other pending req, because the pointer has advanced past it.
REQ-024 Back-to-back jobs SHALL have exactly one IDLE cycle between DONE and the next START.

Reset
REQ-025 On rst, asynchronously: state=IDLE, grant=0, ack=0, ln_sel=0, ln_start=0, busy=0, err=0, err_id=0, pointer=N_REQ-1 (requester 0 highest priority first), watchdog=0. Reset mid-job SHALL abandon the job with no ack.

Configuration
REQ-026 With macro LN_SCHED_TIMEOUT_EN defined, a watchdog SHALL count WAIT cycles from 0. On reaching TIMEOUT_CYCLES with no ln_done:
- move to DONE;
- pulse ack[w] and err together;
- set err_id=w.
The counter SHALL clear on entry to START.
REQ-027 Without LN_SCHED_TIMEOUT_EN, WAIT SHALL persist until ln_done; err and err_id SHALL be tied 0 and no counter logic SHALL exist.

Verification
REQ-028 Single requester: N_REQ=4, req=4'b0100, ln_done 20 cycles after ln_start -> grant=4'b0100, ln_sel=2, one ln_start pulse, ack[2] one cycle after ln_done, busy low afterwards.
REQ-029 Fairness: req=4'b1111 held through all acks -> grant order 0,1,2,3,0, each job separated by exactly one IDLE cycle.
REQ-030 Spurious done: ln_done pulsed while in IDLE and while in START -> no state change, no ack; the job completes only on a ln_done that arrives in WAIT.
REQ-031 Drop mid-job: req[1] deasserted during WAIT -> ack[1] still pulses after ln_done; no re-grant to requester 1.
REQ-032 Reset mid-job: rst asserted during WAIT -> all outputs 0 immediately; after release, req=4'b0001 is granted to requester 0.
REQ-033 Timeout (LN_SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=16): ln_done never driven -> err and ack[w] pulse 16 cycles into WAIT, err_id=w, block returns to IDLE.
